// File: rtl/ahb_lite_single_master.sv
`default_nettype none
// ============================================================================
// ahb_lite_single_master: valid/ready command -> one non-burst AHB-Lite transfer
// Rev 1.0
// ============================================================================
module ahb_lite_single_master #(
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic        rsp_error,
  output logic [31:0] rsp_rdata,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ADDR   = 2'd1,
    S_DATA   = 2'd2,
    S_BADCMD = 2'd3
  } state_t;

  state_t      state_q;
  logic        cmd_ready_q;
  logic        rsp_valid_q;
  logic        rsp_error_q;
  logic [31:0] rsp_rdata_q;
  logic [31:0] haddr_q;
  logic [1:0]  htrans_q;
  logic        hwrite_q;
  logic [2:0]  hsize_q;
  logic [31:0] hwdata_q;
  logic [31:0] wdata_q;

  logic        cmd_legal_d;
  logic [31:0] hwdata_d;
  logic [31:0] rdata_d;

  always_comb begin
    cmd_legal_d = 1'b1;
    if (cmd_size > 3'd2) begin
      cmd_legal_d = 1'b0;
    end else if ((cmd_size == 3'd1) && cmd_addr[0]) begin
      cmd_legal_d = 1'b0;
    end else if ((cmd_size == 3'd2) && (cmd_addr[1:0] != 2'b00)) begin
      cmd_legal_d = 1'b0;
    end
  end

  // Narrow writes are replicated across all byte lanes so any slave lane decode works.
  always_comb begin
    case (hsize_q)
      3'd0:    hwdata_d = {4{wdata_q[7:0]}};
      3'd1:    hwdata_d = {2{wdata_q[15:0]}};
      default: hwdata_d = wdata_q;
    endcase
  end

  always_comb begin
    rdata_d = '0;
    case (hsize_q)
      3'd0:    rdata_d[7:0]  = HRDATA[{haddr_q[1:0], 3'b000} +: 8];
      3'd1:    rdata_d[15:0] = haddr_q[1] ? HRDATA[31:16] : HRDATA[15:0];
      default: rdata_d       = HRDATA;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
      haddr_q     <= '0;
      htrans_q    <= TR_IDLE;
      hwrite_q    <= 1'b0;
      hsize_q     <= '0;
      hwdata_q    <= '0;
      wdata_q     <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            if (cmd_legal_d) begin
              state_q  <= S_ADDR;
              htrans_q <= TR_NONSEQ;
              haddr_q  <= cmd_addr;
              hwrite_q <= cmd_write;
              hsize_q  <= cmd_size;
              wdata_q  <= cmd_wdata;
            end else begin
              state_q <= S_BADCMD;
            end
          end
        end
        S_BADCMD: begin
          state_q     <= S_IDLE;
          cmd_ready_q <= 1'b1;
          rsp_valid_q <= 1'b1;
          rsp_error_q <= 1'b1;
          rsp_rdata_q <= '0;
        end
        S_ADDR: begin
          if (HREADY) begin
            state_q  <= S_DATA;
            htrans_q <= TR_IDLE;
            if (hwrite_q) begin
              hwdata_q <= hwdata_d;
            end
          end
        end
        S_DATA: begin
          // First ERROR cycle has HREADY low; only the HREADY-high cycle completes.
          if (HREADY) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= HRESP;
            rsp_rdata_q <= (!hwrite_q && !HRESP) ? rdata_d : 32'h0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_error = rsp_error_q;
  assign rsp_rdata = rsp_rdata_q;
  assign HADDR     = haddr_q;
  assign HTRANS    = htrans_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = hsize_q;
  assign HWDATA    = hwdata_q;
  assign HBURST    = 3'b000;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_single_master.sv
`default_nettype none
// ============================================================================
// tb_ahb_lite_single_master: randomized bench with transaction-level model and slave
// Rev 1.0
// ============================================================================
module tb_ahb_lite_single_master;

  logic        HCLK, HRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [2:0]  cmd_size;
  logic        rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  ahb_lite_single_master #(.HPROT_VAL(4'b0011)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_rdata(rsp_rdata),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  typedef struct {
    int          e;      // cycle index in which the DUT holds the accepted command
    int          aw;     // address-phase stall cycles
    int          dw;     // data-phase wait cycles
    bit          legal;
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] hwdata;
    bit          err;
    logic [31:0] rd;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        plan_q[$];
  logic [31:0] mem_m [64];
  logic [31:0] mem_s [64];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  bit          last_err = 1'b0;
  logic [31:0] last_rd = 32'h0;

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  always @(posedge HCLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit is_legal(input logic [2:0] s, input logic [31:0] a);
    if (s > 3'd2) return 1'b0;
    if (s == 3'd1 && a[0]) return 1'b0;
    if (s == 3'd2 && a[1:0] != 2'b00) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int resp_cycle(input txn_t t);
    return t.legal ? (t.e + t.aw + t.dw + 2) : (t.e + 1);
  endfunction

  // Drive one command, hold it until accepted, and record what the model predicts.
  task automatic issue(input bit wr, input logic [31:0] a, input logic [2:0] s,
                       input logic [31:0] d, input int aw, input int dw, input bit er,
                       output txn_t t);
    int budget = 0;
    int nb, ln, idx;
    @(negedge HCLK);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_size = s; cmd_wdata = d;
    while (cmd_ready !== 1'b1) begin
      @(negedge HCLK);
      budget++;
      if (budget > 200) begin
        chk("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    t.e = cyc + 1; t.aw = aw; t.dw = dw; t.wr = wr; t.addr = a; t.size = s;
    t.legal = is_legal(s, a);
    t.err = t.legal ? er : 1'b1;
    nb  = 1 << s;
    ln  = int'(a[1:0]);
    idx = int'(a[7:2]);
    for (int i = 0; i < 4; i++) t.hwdata[8*i +: 8] = d[8*(i % nb) +: 8];
    t.rd = 32'h0;
    if (t.legal && !er) begin
      for (int i = 0; i < nb; i++) begin
        if (wr) mem_m[idx][8*(ln+i) +: 8] = d[8*i +: 8];
        else    t.rd[8*i +: 8] = mem_m[idx][8*(ln+i) +: 8];
      end
    end
    exp_q.push_back(t);
    if (t.legal) plan_q.push_back(t);
    @(posedge HCLK);
    #1;
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_size = 3'($urandom); cmd_wdata = $urandom;
  endtask

  task automatic wait_rsp(input txn_t t, input int lat, input logic [31:0] rd, input bit er);
    int n = 0;
    forever begin
      @(negedge HCLK);
      if (rsp_valid === 1'b1) break;
      n++;
      if (n > 40) begin
        chk("rsp_timeout", 32'd0, 32'd1);
        return;
      end
    end
    chk("latency", cyc - t.e, lat);
    chk("rsp_rdata_lit", rsp_rdata, rd);
    chk("rsp_error_lit", {31'd0, rsp_error}, {31'd0, er});
    chk("model_rd", t.rd, rd);
    chk("model_err", {31'd0, t.err}, {31'd0, er});
  endtask

  // Memory slave: reacts to the bus and follows the wait/error plan of each transfer.
  initial begin
    int   ph = 0, aw_left = 0, dw_left = 0, idx, nb, ln;
    txn_t sp;
    logic [31:0] s_addr;
    logic [2:0]  s_size;
    bit          s_wr, s_err;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
    s_addr = 0; s_size = 0; s_wr = 0; s_err = 0;
    forever begin
      @(negedge HCLK);
      HRDATA = $urandom; HRESP = 1'b0; HREADY = 1'b1;
      if (!HRESETn) begin
        ph = 0;
      end else begin
        if (ph == 0 && HTRANS == 2'b10) begin
          chk("transfer_planned", plan_q.size() != 0, 32'd1);
          if (plan_q.size() != 0) sp = plan_q.pop_front();
          else begin sp.aw = 0; sp.dw = 0; sp.err = 0; end
          aw_left = sp.aw;
          ph = 1;
        end
        if (ph == 1) begin
          if (aw_left > 0) begin
            HREADY = 1'b0;
            aw_left--;
          end else begin
            s_addr = HADDR; s_size = HSIZE; s_wr = HWRITE;
            dw_left = sp.dw; s_err = sp.err;
            ph = 2;
          end
        end else if (ph == 2) begin
          if (dw_left > 0) begin
            HREADY = 1'b0;
            HRESP  = s_err && (dw_left == 1);
            dw_left--;
          end else begin
            HRESP = s_err;
            idx = int'(s_addr[7:2]);
            ln  = int'(s_addr[1:0]);
            nb  = 1 << s_size;
            if (!s_err) begin
              if (s_wr) begin
                for (int b = ln; b < ln + nb && b < 4; b++) mem_s[idx][8*b +: 8] = HWDATA[8*b +: 8];
              end else begin
                HRDATA = mem_s[idx];
              end
            end
            ph = 0;
          end
        end
      end
    end
  end

  // Cycle-by-cycle compare of all DUT outputs against the transaction model.
  initial begin
    txn_t t;
    bit   have;
    int   rc;
    forever begin
      @(negedge HCLK);
      if (HRESETn === 1'b1) begin
        have = (exp_q.size() > 0) && (exp_q[0].e <= cyc);
        rc = 0;
        if (have) begin
          t  = exp_q[0];
          rc = resp_cycle(t);
        end
        chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, (!have || cyc == rc)});
        if (have && t.legal && cyc <= t.e + t.aw) begin
          chk("HTRANS", {30'd0, HTRANS}, 32'd2);
          chk("HADDR", HADDR, t.addr);
          chk("HWRITE", {31'd0, HWRITE}, {31'd0, t.wr});
          chk("HSIZE", {29'd0, HSIZE}, {29'd0, t.size});
        end else begin
          chk("HTRANS", {30'd0, HTRANS}, 32'd0);
        end
        if (have && t.legal && t.wr && cyc > t.e + t.aw && cyc < rc)
          chk("HWDATA", HWDATA, t.hwdata);
        chk("HBURST", {29'd0, HBURST}, 32'd0);
        chk("HPROT", {28'd0, HPROT}, 32'd3);
        chk("HMASTLOCK", {31'd0, HMASTLOCK}, 32'd0);
        if (have && cyc == rc) begin
          chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
          chk("rsp_error", {31'd0, rsp_error}, {31'd0, t.err});
          chk("rsp_rdata", rsp_rdata, t.rd);
          last_err = t.err;
          last_rd  = t.rd;
          void'(exp_q.pop_front());
        end else begin
          chk("rsp_valid", {31'd0, rsp_valid}, 32'd0);
          chk("rsp_error_hold", {31'd0, rsp_error}, {31'd0, last_err});
          chk("rsp_rdata_hold", rsp_rdata, last_rd);
        end
      end
    end
  end

  initial begin
    txn_t t;
    int   aw, dw, r, n;
    bit   er;
    logic [2:0]  s;
    logic [31:0] a;
    for (int i = 0; i < 64; i++) begin mem_m[i] = 32'h0; mem_s[i] = 32'h0; end
    HRESETn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_size = 3'd0; cmd_wdata = 32'h0;
    repeat (3) @(negedge HCLK);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_HTRANS", {30'd0, HTRANS}, 32'd0);
    chk("rst_HADDR", HADDR, 32'd0);
    chk("rst_HWDATA", HWDATA, 32'd0);
    HRESETn = 1'b1;

    issue(1'b1, 32'h20, 3'd2, 32'hDEADBEEF, 0, 0, 1'b0, t);
    chk("model_hwdata_word", t.hwdata, 32'hDEADBEEF);
    wait_rsp(t, 2, 32'h0, 1'b0);
    issue(1'b0, 32'h20, 3'd2, 32'h0, 0, 0, 1'b0, t);
    wait_rsp(t, 2, 32'hDEADBEEF, 1'b0);
    issue(1'b1, 32'h23, 3'd0, 32'h000000A5, 0, 0, 1'b0, t);
    chk("model_hwdata_byte", t.hwdata, 32'hA5A5A5A5);
    wait_rsp(t, 2, 32'h0, 1'b0);
    issue(1'b0, 32'h20, 3'd2, 32'h0, 0, 0, 1'b0, t);
    wait_rsp(t, 2, 32'hA5ADBEEF, 1'b0);
    issue(1'b0, 32'h23, 3'd0, 32'h0, 0, 0, 1'b0, t);
    wait_rsp(t, 2, 32'h000000A5, 1'b0);
    issue(1'b0, 32'h22, 3'd1, 32'h0, 0, 3, 1'b0, t);
    wait_rsp(t, 5, 32'h0000A5AD, 1'b0);
    issue(1'b1, 32'h24, 3'd2, 32'h11223344, 0, 1, 1'b1, t);
    wait_rsp(t, 3, 32'h0, 1'b1);
    issue(1'b0, 32'h22, 3'd2, 32'h0, 0, 0, 1'b0, t);
    wait_rsp(t, 1, 32'h0, 1'b1);
    issue(1'b1, 32'h40, 3'd3, 32'h55555555, 0, 0, 1'b0, t);
    wait_rsp(t, 1, 32'h0, 1'b1);
    issue(1'b0, 32'h20, 3'd2, 32'h0, 1, 0, 1'b0, t);
    wait_rsp(t, 3, 32'hA5ADBEEF, 1'b0);

    // Abort a read in its data-phase wait states.
    issue(1'b0, 32'h20, 3'd2, 32'h0, 0, 6, 1'b0, t);
    repeat (3) @(negedge HCLK);
    #2;
    HRESETn = 1'b0;
    #1;
    chk("arst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("arst_rsp_error", {31'd0, rsp_error}, 32'd0);
    chk("arst_rsp_rdata", rsp_rdata, 32'd0);
    chk("arst_HTRANS", {30'd0, HTRANS}, 32'd0);
    chk("arst_HADDR", HADDR, 32'd0);
    chk("arst_HSIZE", {29'd0, HSIZE}, 32'd0);
    chk("arst_HWRITE", {31'd0, HWRITE}, 32'd0);
    chk("arst_HWDATA", HWDATA, 32'd0);
    exp_q.delete();
    plan_q.delete();
    last_err = 1'b0;
    last_rd  = 32'h0;
    @(negedge HCLK);
    #2;
    HRESETn = 1'b1;
    issue(1'b1, 32'h30, 3'd2, 32'h12345678, 0, 0, 1'b0, t);
    wait_rsp(t, 2, 32'h0, 1'b0);
    issue(1'b0, 32'h32, 3'd1, 32'h0, 0, 0, 1'b0, t);
    wait_rsp(t, 2, 32'h00001234, 1'b0);

    for (int k = 0; k < 400; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge HCLK);
      r  = $urandom_range(0, 15);
      s  = (r == 0) ? 3'd3 : 3'(r % 3);
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (s == 3'd1) a[0] = 1'b0;
        if (s == 3'd2) a[1:0] = 2'b00;
      end
      aw = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      dw = $urandom_range(0, 3);
      er = ($urandom_range(0, 7) == 0);
      if (er && dw == 0) dw = 1;
      issue(1'($urandom), a, s, $urandom, aw, dw, er, t);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge HCLK);
      n++;
    end
    chk("drain", exp_q.size(), 32'd0);
    repeat (3) @(negedge HCLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
